// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encodings and default width for the serial subtractor
// Ports: none (package)
package serial_sub_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/serial_sub_half_sub.sv
// half_sub: one-bit half subtractor
// Ports: x minuend bit, y subtrahend bit, d difference x^y, bo borrow-out ~x&y
module half_sub (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor computing a - b mod 2^WIDTH over WIDTH cycles
// Ports: clk, rst (async, active-high), start/a/b request and operands,
//        busy (SHIFT state), done (one-cycle result pulse), diff/borrow result
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_diff;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             w_d1, w_bo1, w_d, w_bo2, w_last, w_accept;
    // full subtractor: (a0 - b0) then minus the stored borrow
    half_sub u_hs0 (.x(r_a[0]), .y(r_b[0]),   .d(w_d1), .bo(w_bo1));
    half_sub u_hs1 (.x(w_d1),   .y(r_borrow), .d(w_d),  .bo(w_bo2));
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_accept = r_state == IDLE && start;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE:    w_next = start ? SHIFT : IDLE;
            SHIFT: begin
                busy   = 1'b1;
                w_next = w_last ? DONE : SHIFT;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == SHIFT) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            // LSB-first result bits enter at the top so the word is aligned after WIDTH shifts
            r_diff   <= WIDTH'({w_d, r_diff} >> 1);
            r_borrow <= w_bo1 | w_bo2;
            r_cnt    <= r_cnt + CW'(1);
        end
    end
    assign diff   = r_diff;
    assign borrow = r_borrow;
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at WIDTH=8 and WIDTH=1
module tb_serial_sub;
    logic       clk = 0, rst = 0, start8 = 0, start1 = 0;
    logic [7:0] a8 = 0, b8 = 0, diff8;
    logic [0:0] a1 = 0, b1 = 0, diff1;
    logic       busy8, done8, borrow8, busy1, done1, borrow1;
    int         total = 0, bad = 0, cyc = 0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];
    int         done_t8[$];

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );
    serial_sub #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref8(int x, int y);
        return {x < y, 8'(x - y)};
    endfunction

    function automatic logic [1:0] ref1(int x, int y);
        return {x < y, 1'(x - y)};
    endfunction

    int   run8 = 0, run1 = 0;
    logic pd8 = 0, pd1 = 0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            run8 = 0;
            pd8  = 0;
        end else begin
            if (busy8) run8++;
            else if (run8 > 0) begin
                chk("busy8_len", run8, 8);
                chk("done8_after_busy", done8, 1);
                run8 = 0;
            end
            if (done8) begin
                chk("done8_single_pulse", pd8, 0);
                done_t8.push_back(cyc);
                chk("done8_expected", q8.size() > 0, 1);
                if (q8.size() > 0) begin
                    e = q8.pop_front();
                    chk("diff8", diff8, e[7:0]);
                    chk("borrow8", borrow8, e[8]);
                end
            end
            pd8 = done8;
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (rst) begin
            run1 = 0;
            pd1  = 0;
        end else begin
            if (busy1) run1++;
            else if (run1 > 0) begin
                chk("busy1_len", run1, 1);
                chk("done1_after_busy", done1, 1);
                run1 = 0;
            end
            if (done1) begin
                chk("done1_single_pulse", pd1, 0);
                chk("done1_expected", q1.size() > 0, 1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    chk("diff1", diff1, e[0]);
                    chk("borrow1", borrow1, e[1]);
                end
            end
            pd1 = done1;
        end
    end

    task automatic wait_idle8();
        for (int i = 0; i < 40 && (busy8 || done8); i++) @(negedge clk);
        chk("idle8_wait", busy8 | done8, 0);
    endtask

    task automatic op8(logic [7:0] x, logic [7:0] y, bit expect_done);
        wait_idle8();
        a8 = x;
        b8 = y;
        start8 = 1;
        if (expect_done) q8.push_back(ref8(x, y));
        @(negedge clk);
        start8 = 0;
    endtask

    task automatic drain8();
        for (int i = 0; i < 60 && q8.size() > 0; i++) @(negedge clk);
        chk("drain8", q8.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic op1(logic x, logic y);
        for (int i = 0; i < 10 && (busy1 || done1); i++) @(negedge clk);
        chk("idle1_wait", busy1 | done1, 0);
        a1 = x;
        b1 = y;
        start1 = 1;
        q1.push_back(ref1(int'(x), int'(y)));
        @(negedge clk);
        start1 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        #1 rst = 1;
        #1;
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_diff8", diff8, 0);
        chk("rst_borrow8", borrow8, 0);
        chk("rst_busy1", busy1, 0);
        @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        op8(100, 37, 1);
        drain8();
        op8(0, 1, 1);
        op8(8'h55, 8'h55, 1);
        drain8();
        // start during SHIFT must be ignored
        op8(200, 77, 1);
        repeat (3) @(negedge clk);
        a8 = 9;
        b8 = 3;
        start8 = 1;
        @(negedge clk);
        start8 = 0;
        drain8();
        repeat (12) @(negedge clk);
        // asynchronous reset in the fourth SHIFT cycle aborts silently
        op8(8'd1, 8'd2, 0);
        repeat (3) @(negedge clk);
        chk("busy8_before_abort", busy8, 1);
        #2 rst = 1;
        #1;
        chk("async_busy8", busy8, 0);
        chk("async_done8", done8, 0);
        chk("async_diff8", diff8, 0);
        chk("async_borrow8", borrow8, 0);
        #9 rst = 0;
        @(negedge clk);
        op8(50, 60, 1);
        drain8();
        repeat (12) @(negedge clk);
        // back-to-back with start held high
        wait_idle8();
        nd = done_t8.size();
        a8 = 10;
        b8 = 3;
        start8 = 1;
        q8.push_back(ref8(10, 3));
        q8.push_back(ref8(3, 10));
        @(negedge clk);
        a8 = 3;
        b8 = 10;
        for (int i = 0; i < 30 && done_t8.size() < nd + 1; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        start8 = 0;
        for (int i = 0; i < 30 && done_t8.size() < nd + 2; i++) @(negedge clk);
        chk("b2b_done_count", done_t8.size() - nd, 2);
        if (done_t8.size() >= nd + 2) chk("b2b_spacing", done_t8[nd+1] - done_t8[nd], 10);
        drain8();
        // random operands with random idle gaps
        for (int k = 0; k < 20; k++) begin
            op8(8'($urandom), 8'($urandom), 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        op8(8'hff, 8'h00, 1);
        op8(8'h00, 8'hff, 1);
        drain8();
        // WIDTH=1 exhaustive
        for (int k = 0; k < 4; k++) op1(k[1], k[0]);
        for (int i = 0; i < 20 && q1.size() > 0; i++) @(negedge clk);
        chk("drain1", q1.size(), 0);
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
